// File: rtl/tic_tac_toe_ai_pkg.sv
// Shared board encodings, win-line table, pick order and AI FSM states for tic_tac_toe.
package tic_tac_toe_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] PX    = 2'd1;
  localparam logic [1:0] PO    = 2'd2;

  typedef logic [3:0] cell_idx_t;

  localparam cell_idx_t WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Center, corners, edges; corner slots 1..4 may be rotated by the random option.
  localparam cell_idx_t PICK_ORDER [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_WIN,
    S_SCAN_BLOCK,
    S_PICK,
    S_ISSUE,
    S_WAIT
  } ai_state_t;

  function automatic logic [1:0] cell_at(input logic [17:0] board, input cell_idx_t idx);
    return board[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/tic_tac_toe_ai_if.sv
// Engine <-> AI signal bundle: engine state toward the AI, move strobe back.
interface tic_tac_toe_ai_if;
  logic        enable;
  logic [17:0] board_flat;
  logic [1:0]  current_player;
  logic [1:0]  winner;
  logic        draw;
  logic        move_valid;
  logic [3:0]  move_pos;
  logic        busy;

  modport master (
    output enable, board_flat, current_player, winner, draw,
    input  move_valid, move_pos, busy
  );

  modport slave (
    input  enable, board_flat, current_player, winner, draw,
    output move_valid, move_pos, busy
  );
endinterface

// File: rtl/tic_tac_toe_ai_line_eval.sv
// Combinational check of one win line: two cells owned by i_player and the third empty.
module ttt_line_eval
  import tic_tac_toe_pkg::*;
(
  input  logic [1:0] i_c0,
  input  logic [1:0] i_c1,
  input  logic [1:0] i_c2,
  input  logic [1:0] i_player,
  output logic       o_hit,
  output logic [1:0] o_slot
);
  always_comb begin
    o_hit  = 1'b0;
    o_slot = '0;
    if (i_c0 == i_player && i_c1 == i_player && i_c2 == EMPTY) begin
      o_hit  = 1'b1;
      o_slot = 2'd2;
    end else if (i_c0 == i_player && i_c2 == i_player && i_c1 == EMPTY) begin
      o_hit  = 1'b1;
      o_slot = 2'd1;
    end else if (i_c1 == i_player && i_c2 == i_player && i_c0 == EMPTY) begin
      o_hit  = 1'b1;
      o_slot = 2'd0;
    end
  end
endmodule

// File: rtl/tic_tac_toe_ai.sv
// Tic-tac-toe opponent: win / block / center / corner / edge move selection with retry.
// Optional macro TTT_AI_RANDOM_EN rotates the corner search start with an 8-bit LFSR.
module tic_tac_toe_ai
  import tic_tac_toe_pkg::*;
#(
  parameter logic [1:0]  AI_PLAYER      = 2'd2,
  parameter int unsigned ACCEPT_TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset_n,
  tic_tac_toe_ai_if.slave  ai_bus
);
  localparam logic [1:0]  OPP   = 2'(3 - AI_PLAYER);
  localparam int unsigned TW    = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(ACCEPT_TIMEOUT - 1);

  ai_state_t   r_state;
  logic [17:0] r_snap;
  logic [2:0]  r_line;
  logic [TW-1:0] r_tcnt;
  logic        r_move_valid;
  logic [3:0]  r_move_pos;

  logic        w_active, w_abort, w_hit, w_pick_found;
  logic [1:0]  w_player, w_slot, w_corner_start;
  cell_idx_t   w_l0, w_l1, w_l2, w_hit_pos, w_pick_pos, w_try;

  assign w_active = ai_bus.enable && (ai_bus.current_player == AI_PLAYER) &&
                    (ai_bus.winner == 2'd0) && !ai_bus.draw;
  assign w_abort  = !ai_bus.enable || (ai_bus.winner != 2'd0) || ai_bus.draw;

  assign w_player  = (r_state == S_SCAN_BLOCK) ? OPP : AI_PLAYER;
  assign w_l0      = WIN_LINES[r_line][0];
  assign w_l1      = WIN_LINES[r_line][1];
  assign w_l2      = WIN_LINES[r_line][2];
  assign w_hit_pos = (w_slot == 2'd2) ? w_l2 : (w_slot == 2'd1) ? w_l1 : w_l0;

  ttt_line_eval u_line_eval (
    .i_c0     (cell_at(r_snap, w_l0)),
    .i_c1     (cell_at(r_snap, w_l1)),
    .i_c2     (cell_at(r_snap, w_l2)),
    .i_player (w_player),
    .o_hit    (w_hit),
    .o_slot   (w_slot)
  );

`ifdef TTT_AI_RANDOM_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lfsr <= 8'h5A;
    else          r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
  end
  assign w_corner_start = r_lfsr[1:0];
`else
  assign w_corner_start = '0;
`endif

  // Corner entries of PICK_ORDER are visited rotated by w_corner_start; zero gives the fixed order.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_pos   = '0;
    w_try        = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      if (k >= 1 && k <= 4)
        w_try = PICK_ORDER[4'(1 + ((k - 1 + 32'(w_corner_start)) & 32'd3))];
      else
        w_try = PICK_ORDER[4'(k)];
      if (!w_pick_found && cell_at(r_snap, w_try) == EMPTY) begin
        w_pick_found = 1'b1;
        w_pick_pos   = w_try;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_snap       <= '0;
      r_line       <= '0;
      r_tcnt       <= '0;
      r_move_valid <= 1'b0;
      r_move_pos   <= '0;
    end else begin
      r_move_valid <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (w_active) begin
            r_snap  <= ai_bus.board_flat;
            r_line  <= '0;
            r_state <= S_SCAN_WIN;
          end
          S_SCAN_WIN, S_SCAN_BLOCK: begin
            if (w_hit) begin
              r_move_valid <= 1'b1;
              r_move_pos   <= w_hit_pos;
              r_state      <= S_ISSUE;
            end else if (r_line == 3'd7) begin
              r_line  <= '0;
              r_state <= (r_state == S_SCAN_WIN) ? S_SCAN_BLOCK : S_PICK;
            end else begin
              r_line <= r_line + 3'd1;
            end
          end
          S_PICK: begin
            if (w_pick_found) begin
              r_move_valid <= 1'b1;
              r_move_pos   <= w_pick_pos;
              r_state      <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_ISSUE: begin
            r_tcnt  <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (ai_bus.board_flat != r_snap || ai_bus.current_player != AI_PLAYER) begin
              r_state <= S_IDLE;
            end else if (r_tcnt == TLAST) begin
              // r_move_pos still holds the candidate, so a retry just re-strobes it.
              r_move_valid <= 1'b1;
              r_state      <= S_ISSUE;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ai_bus.move_valid = r_move_valid;
  assign ai_bus.move_pos   = r_move_pos;
  assign ai_bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_tic_tac_toe_ai.sv
// Directed bench for tic_tac_toe_ai (AI plays O, ACCEPT_TIMEOUT = 15), bench acts as the engine.
module tb_tic_tac_toe_ai;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  tic_tac_toe_ai_if bus ();

  tic_tac_toe_ai #(
    .AI_PLAYER      (2'd2),
    .ACCEPT_TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ai_bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] put(input logic [17:0] b, input int idx, input logic [1:0] v);
    b[2*idx +: 2] = v;
    return b;
  endfunction

  // Waits up to 40 cycles for a strobe; lat counts posedges since the call.
  task automatic wait_move(output int lat, output int pos);
    bit seen;
    seen = 1'b0;
    lat  = 99;
    pos  = -1;
    for (int i = 1; i <= 40; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (bus.move_valid === 1'b1) begin
          seen = 1'b1;
          lat  = i;
          pos  = int'(bus.move_pos);
        end
      end
    end
  endtask

  task automatic start_turn(input logic [17:0] b);
    @(negedge clk);
    bus.board_flat     = b;
    bus.current_player = 2'd2;
  endtask

  // Engine accepts the move: board updated, turn passes to X; FSM must go idle.
  task automatic accept(input string tag, inout logic [17:0] b, input int pos);
    @(negedge clk);
    b = put(b, pos, 2'd2);
    bus.board_flat     = b;
    bus.current_player = 2'd1;
    @(posedge clk); #1;
    check({tag, "_single"}, int'(bus.move_valid), 0);
    @(posedge clk); #1;
    check({tag, "_idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    logic [17:0] b;
    int lat, pos;
    bit any_valid;

    bus.enable = 1'b1;
    bus.board_flat = '0;
    bus.current_player = 2'd1;
    bus.winner = 2'd0;
    bus.draw = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(bus.move_valid), 0);
    check("rst_pos",   int'(bus.move_pos),   0);
    check("rst_busy",  int'(bus.busy),       0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("not_my_turn_busy", int'(bus.busy), 0);

    // Empty board: full scan then center pick.
    b = '0;
    start_turn(b);
    wait_move(lat, pos);
    check("empty_lat", lat, 18);
    check("empty_pos", pos, 4);
    accept("empty", b, pos);

    // O at 0,1 and X at 3,4: own win on line 0 beats the block.
    b = '0;
    b = put(b, 0, 2'd2); b = put(b, 1, 2'd2);
    b = put(b, 3, 2'd1); b = put(b, 4, 2'd1);
    start_turn(b);
    wait_move(lat, pos);
    check("win_lat", lat, 2);
    check("win_pos", pos, 2);
    accept("win", b, pos);

    // X at 0,4 and O at 2: block on diagonal {0,4,8}, then retry while engine ignores it.
    b = '0;
    b = put(b, 0, 2'd1); b = put(b, 4, 2'd1); b = put(b, 2, 2'd2);
    start_turn(b);
    wait_move(lat, pos);
    check("block_lat", lat, 16);
    check("block_pos", pos, 8);
    wait_move(lat, pos);
    check("retry_period", lat, 16);
    check("retry_pos",    pos, 8);
    accept("retry", b, pos);

    // enable dropped during SCAN_BLOCK.
    b = '0;
    start_turn(b);
    repeat (12) @(posedge clk);
    #1;
    check("scan_busy", int'(bus.busy), 1);
    @(negedge clk);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    check("disable_busy",  int'(bus.busy), 0);
    check("disable_valid", int'(bus.move_valid), 0);
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.move_valid === 1'b1) any_valid = 1'b1;
    end
    check("disable_no_move", int'(any_valid), 0);
    @(negedge clk);
    bus.current_player = 2'd1;
    bus.enable = 1'b1;

    // Winner asserted mid-scan aborts.
    start_turn(b);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.winner = 2'd1;
    @(posedge clk); #1;
    check("winner_abort_busy", int'(bus.busy), 0);
    @(negedge clk);
    bus.winner = 2'd0;
    bus.current_player = 2'd1;

    // Async reset mid-WAIT.
    b = '0;
    b = put(b, 0, 2'd1); b = put(b, 4, 2'd1); b = put(b, 2, 2'd2);
    start_turn(b);
    wait_move(lat, pos);
    check("pre_reset_pos", pos, 8);
    repeat (3) @(posedge clk);
    #1;
    check("wait_busy", int'(bus.busy), 1);
    reset_n = 1'b0;
    #1;
    check("reset_busy",  int'(bus.busy),       0);
    check("reset_valid", int'(bus.move_valid), 0);
    check("reset_pos",   int'(bus.move_pos),   0);
    @(negedge clk);
    bus.current_player = 2'd1;
    reset_n = 1'b1;

    // Short game: human X plays 4, 8, 6; AI answers 0, 2, then wins at 1.
    b = '0;
    b = put(b, 4, 2'd1);
    start_turn(b);
    wait_move(lat, pos);
    check("g1_lat", lat, 18);
    check("g1_pos", pos, 0);
    accept("g1", b, pos);
    b = put(b, 8, 2'd1);
    start_turn(b);
    wait_move(lat, pos);
    check("g2_lat", lat, 18);
    check("g2_pos", pos, 2);
    accept("g2", b, pos);
    b = put(b, 6, 2'd1);
    start_turn(b);
    wait_move(lat, pos);
    check("g3_lat", lat, 2);
    check("g3_pos", pos, 1);
    accept("g3", b, pos);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
